// File: rtl/avbfm_burst_adapter.sv
// VProc bus to Avalon-MM burst manager bridge with a read response FIFO.
// Optional protocol checking is enabled by defining AVBFM_PROTOCOL_CHECK_EN.
module avbfm_burst_adapter #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32,
  parameter int MAXBURST  = 16,
  parameter int BCWIDTH   = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDRWIDTH-1:0]   vp_addr,
  input  logic [DATAWIDTH/8-1:0] vp_be,
  input  logic                   vp_we,
  input  logic [DATAWIDTH-1:0]   vp_dataout,
  input  logic                   vp_rd,
  input  logic [BCWIDTH-1:0]     vp_burst,
  output logic                   vp_wrack,
  output logic                   vp_rdack,
  output logic [DATAWIDTH-1:0]   vp_datain,
  output logic [ADDRWIDTH-1:0]   av_address,
  output logic [DATAWIDTH/8-1:0] av_byteenable,
  output logic [BCWIDTH-1:0]     av_burstcount,
  output logic                   av_write,
  output logic [DATAWIDTH-1:0]   av_writedata,
  output logic                   av_read,
  input  logic                   av_waitrequest,
  input  logic [DATAWIDTH-1:0]   av_readdata,
  input  logic                   av_readdatavalid,
  output logic                   err
);
  localparam int BEW = DATAWIDTH / 8;
  localparam int PW  = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
  localparam int CW  = $clog2(MAXBURST + 1);

  typedef enum logic [1:0] {IDLE, WR, RD_CMD, RD_DATA} state_t;
  state_t state, state_nxt;

  logic [ADDRWIDTH-1:0] addr_q;
  logic [BEW-1:0]       be_q;
  logic [BCWIDTH-1:0]   bc_q, beat, burst_eff, beat_nxt;
  logic [DATAWIDTH-1:0] mem [MAXBURST];
  logic [PW-1:0]        wptr, rptr;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 in_rd, push, pop, start;

  // Zero-length bursts become single beats; oversize bursts are clamped.
  always_comb begin
    burst_eff = vp_burst;
    if (vp_burst == '0)
      burst_eff = BCWIDTH'(1);
    else if (vp_burst > BCWIDTH'(MAXBURST))
      burst_eff = BCWIDTH'(MAXBURST);
  end

  assign in_rd    = (state == RD_CMD) || (state == RD_DATA);
  assign start    = (state == IDLE) && (vp_we || vp_rd);
  // Beats past burstcount are discarded so the FIFO cannot overflow.
  assign push     = av_readdatavalid && in_rd && (beat < bc_q);
  assign vp_wrack = (state == WR) && vp_we && !av_waitrequest;
  assign vp_rdack = (state == RD_DATA) && vp_rd && (cnt != '0);
  assign pop      = vp_rdack;
  assign beat_nxt = beat + BCWIDTH'(push);
  assign cnt_nxt  = cnt + CW'(push) - CW'(pop);

  assign av_address    = addr_q;
  assign av_byteenable = be_q;
  assign vp_datain     = (cnt != '0) ? mem[rptr] : '0;

  always_comb begin
    state_nxt     = state;
    av_write      = 1'b0;
    av_read       = 1'b0;
    av_burstcount = '0;
    av_writedata  = '0;
    case (state)
      IDLE: begin
        if (vp_we)      state_nxt = WR;
        else if (vp_rd) state_nxt = RD_CMD;
      end
      WR: begin
        av_write      = vp_we;
        av_writedata  = vp_dataout;
        av_burstcount = bc_q;
        if (vp_wrack && (beat + BCWIDTH'(1) == bc_q)) state_nxt = IDLE;
      end
      RD_CMD: begin
        av_read       = 1'b1;
        av_burstcount = bc_q;
        if (!av_waitrequest) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if ((beat_nxt == bc_q) && (cnt_nxt == '0)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      be_q   <= '0;
      bc_q   <= '0;
      beat   <= '0;
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        addr_q <= vp_addr;
        be_q   <= vp_be;
        bc_q   <= burst_eff;
        beat   <= '0;
      end else if (vp_wrack || push) begin
        beat <= beat + BCWIDTH'(1);
      end
      if (push) wptr <= (wptr == PW'(MAXBURST - 1)) ? '0 : wptr + PW'(1);
      if (pop)  rptr <= (rptr == PW'(MAXBURST - 1)) ? '0 : rptr + PW'(1);
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= av_readdata;
  end

`ifdef AVBFM_PROTOCOL_CHECK_EN
  localparam int AL = (BEW > 1) ? $clog2(BEW) : 1;
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      if (av_readdatavalid && !in_rd) begin
        err_q <= 1'b1;
        $display("%0t avbfm: readdatavalid outside a read", $time);
      end
      if (av_readdatavalid && in_rd && (beat >= bc_q)) begin
        err_q <= 1'b1;
        $display("%0t avbfm: readdatavalid beyond burstcount", $time);
      end
      if (start && (vp_burst > BCWIDTH'(MAXBURST))) begin
        err_q <= 1'b1;
        $display("%0t avbfm: burst %0d exceeds MAXBURST", $time, vp_burst);
      end
      if (start && (vp_addr[AL-1:0] != '0)) begin
        err_q <= 1'b1;
        $display("%0t avbfm: misaligned address %0h", $time, vp_addr);
      end
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: doc/avbfm_burst_adapter.md
Name: avbfm_burst_adapter

Overview:
Bridges a VProc-style processor bus (address, byte enables, read/write strobes with per-beat acks, burst length) to a full Avalon-MM manager interface with waitrequest, burstcount and pipelined readdatavalid. It is the burst-capable successor to the single-beat Avalon BFM wrapper, and sits between a VProc/VProc64 instance and the Avalon interconnect. A read response FIFO absorbs readdatavalid beats, because Avalon cannot backpressure them.

Parameters:
ADDRWIDTH, 32, address width; 32 or 64.
DATAWIDTH, 32, data width; 32 or 64. Byte-enable width is DATAWIDTH/8.
MAXBURST, 16, maximum burst length in beats; read FIFO depth equals MAXBURST (power of 2, 1..256).
BCWIDTH, 5, burstcount width; must satisfy 2**(BCWIDTH-1) >= MAXBURST.

Ports:
clk  input  1  clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
vp_addr  input  ADDRWIDTH  VProc address, valid with vp_we/vp_rd at burst start
vp_be  input  DATAWIDTH/8  VProc byte enables
vp_we  input  1  VProc write strobe, held until the last beat is acked
vp_dataout  input  DATAWIDTH  VProc write data for the current beat
vp_rd  input  1  VProc read strobe, held until the last beat is acked
vp_burst  input  BCWIDTH  burst length in beats; 0 is treated as 1
vp_wrack  output  1  write beat accepted
vp_rdack  output  1  read beat delivered
vp_datain  output  DATAWIDTH  read data, valid with vp_rdack
av_address  output  ADDRWIDTH  Avalon address, constant for the whole burst
av_byteenable  output  DATAWIDTH/8  Avalon byte enables
av_burstcount  output  BCWIDTH  Avalon burst length
av_write  output  1  Avalon write
av_writedata  output  DATAWIDTH  Avalon write data
av_read  output  1  Avalon read command
av_waitrequest  input  1  Avalon backpressure
av_readdata  input  DATAWIDTH  Avalon read data
av_readdatavalid  input  1  Avalon read data valid
err  output  1  sticky protocol error flag; see Optional Feature

Behaviour:
- Reset: FSM goes to IDLE; FIFO, beat counters and err are cleared. All outputs read 0 in the cycle after reset is sampled. A reset mid-burst abandons the burst, and in-flight readdatavalid beats are dropped while reset is high.
- FSM states: IDLE, WR, RD_CMD, RD_DATA.
- IDLE:
  - If vp_we is high, register vp_addr, vp_be and the effective burst (max(vp_burst,1)), then go to WR.
  - Otherwise, if vp_rd is high, register the same fields and go to RD_CMD.
  - If vp_we and vp_rd are both high, the write wins.
  - One cycle of latency from strobe to Avalon command.
- WR:
  - av_write = vp_we; av_writedata = vp_dataout (combinational).
  - Address, byteenable and burstcount are registered and held constant.
  - vp_wrack = av_write & ~av_waitrequest.
  - The beat counter increments on each ack. On the ack of beat burstcount, go to IDLE.
  - If vp_we drops mid-burst, av_write is 0 (Avalon permits gaps) and the state is held.
- RD_CMD:
  - av_read is held at 1 until ~av_waitrequest, then goes to RD_DATA in the next cycle.
  - av_read is asserted for exactly one accepted cycle per burst.
- RD_DATA:
  - Each av_readdatavalid pushes av_readdata into the FIFO. A readdatavalid in the same cycle the command is accepted is also captured.
  - vp_rdack = vp_rd & FIFO not empty; vp_datain = FIFO head; a pop occurs on vp_rdack.
  - A simultaneous push and pop on an empty FIFO does not bypass: the data appears in the next cycle, so minimum read latency is 1 cycle after readdatavalid.
  - Return to IDLE when the received count equals burstcount and the FIFO is empty after the pop.
- FIFO never overflows by construction (depth MAXBURST ≥ burstcount). A burst greater than MAXBURST is clamped to MAXBURST.
- Outside WR and RD_CMD, av_write, av_read and av_burstcount are 0.

Optional Feature:
AVBFM_PROTOCOL_CHECK_EN:
- Defined: err is set (sticky until reset) on any of the following:
  - av_readdatavalid outside RD_CMD/RD_DATA;
  - av_readdatavalid beyond burstcount;
  - vp_burst > MAXBURST at burst start;
  - vp_addr not aligned to DATAWIDTH/8 at burst start.
  Each error also prints a $display message with $time.
- Undefined: err is tied to 0 and no check logic is built.

Test Plan:
- Single write: vp_we, addr 0x100, burst 0, data 0xDEADBEEF, waitrequest low → av_write for 1 cycle with burstcount 1, one vp_wrack, FSM back in IDLE.
- Write burst 4 with waitrequest high on beats 2 and 3 for 2 cycles each → 4 vp_wrack pulses aligned to accepted beats; address 0x200 constant; 8 av_write cycles in total.
- Read burst 8 at 0x300, waitrequest high for 3 cycles, then readdatavalid every cycle with data 0..7 while vp_rd is low for 4 cycles → one accepted av_read with burstcount 8; FIFO holds beats; vp_datain delivers 0..7 in order.
- vp_we and vp_rd asserted together → write executes first, then the read.
- Reset asserted on beat 3 of an 8-beat read → all outputs 0 the next cycle; FIFO empty; a new single read completes normally.
- With AVBFM_PROTOCOL_CHECK_EN: readdatavalid pulsed in IDLE → err goes to 1 and stays set until reset. Without the macro, err stays 0.
